grid_link_controller: RTL

//  Host-side initiator for the system memory serial link (system_memory_v4 serial_in/serial_out).
//  - Write path: takes a DATA_SIZE-bit grid word from a host handshake and shifts it in MSB-first under load_mode.
//  - Read path: reads the grid back by holding output_mode and deserialising serial_out.
//  - Sits between the host/test interface and system memory; it never drives run_mode.

---
 rtl/grid_link_pkg.sv | 19 +
 rtl/grid_link_shift_reg.sv | 40 ++++
 rtl/grid_link_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/grid_link_pkg.sv
// Shared types and helpers for the grid link controller.
package grid_link_pkg;

    // Controller states: idle, shifting a word in, shifting it back out, last-bit capture.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READ,
        DRAIN
    } grid_link_state_e;

    // Bit counter width for a word of data_size bits (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned data_size);
        int unsigned w;
        w = $clog2(data_size);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/grid_link_shift_reg.sv
// Parallel-load, left-shifting register with serial input and MSB serial output.
// Used as the transmit PISO and the receive SIPO of the grid link controller.
module grid_link_shift_reg #(
    parameter int unsigned DATA_SIZE = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 shift_i,
    input  logic                 serial_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 serial_o
);

    logic [DATA_SIZE-1:0] data_q, data_d;

    // Next-state: parallel load has priority over a shift.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            data_d = {data_q[DATA_SIZE-2:0], serial_i};
        end
    end

    // Register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o   = data_q;
    assign serial_o = data_q[DATA_SIZE-1];

endmodule

// File: rtl/grid_link_controller.sv
// Host-side initiator for the system memory serial link.
// Writes a grid word MSB-first under load_mode; reads it back by holding output_mode for one
// full rotation and deserialising serial_out. Never drives run_mode.
// Optional build macro GRID_LINK_VERIFY_EN: every write is followed by an automatic readback
// and compare; a mismatch sets the sticky verify_err flag.
module grid_link_controller
    import grid_link_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_req,
    output logic                 rd_valid,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 busy,
    output logic                 verify_err,
    output logic                 mem_load_mode,
    output logic                 mem_output_mode,
    output logic                 mem_serial_in,
    input  logic                 mem_serial_out
);

    localparam int unsigned    CntW    = cnt_width(DATA_SIZE);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_SIZE - 1);

    grid_link_state_e     state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    // Memory registers serial_out, so a bit is valid the cycle after output_mode was high.
    logic                 out_prev_q, out_prev_d;

    logic                 tx_load;
    logic                 tx_shift;
    logic                 tx_serial;
    logic [DATA_SIZE-1:0] tx_par_unused;
    logic [DATA_SIZE-1:0] rx_word;
    logic                 rx_ser_unused;
    logic [DATA_SIZE-1:0] rx_capture;

`ifdef GRID_LINK_VERIFY_EN
    logic [DATA_SIZE-1:0] wr_word_q, wr_word_d;
    logic                 chk_q, chk_d;
    logic                 verr_q, verr_d;
`endif

    // Transmit shift register: loaded on write acceptance, shifted once per LOAD cycle.
    grid_link_shift_reg #(
        .DATA_SIZE(DATA_SIZE)
    ) u_tx_sr (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (tx_load),
        .data_i  (wr_data),
        .shift_i (tx_shift),
        .serial_i(1'b0),
        .data_o  (tx_par_unused),
        .serial_o(tx_serial)
    );

    // Receive shift register: samples serial_out one cycle behind output_mode.
    grid_link_shift_reg #(
        .DATA_SIZE(DATA_SIZE)
    ) u_rx_sr (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (1'b0),
        .data_i  ({DATA_SIZE{1'b0}}),
        .shift_i (out_prev_q),
        .serial_i(mem_serial_out),
        .data_o  (rx_word),
        .serial_o(rx_ser_unused)
    );

    // Word as it will look after the final shift at the end of DRAIN.
    assign rx_capture = {rx_word[DATA_SIZE-2:0], mem_serial_out};

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        out_prev_d = (state_q == READ);
`ifdef GRID_LINK_VERIFY_EN
        wr_word_d  = wr_word_q;
        chk_d      = chk_q;
        verr_d     = verr_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Write has priority; a held rd_req is picked up on a later IDLE cycle.
                if (wr_valid) begin
                    tx_load = 1'b1;
                    cnt_d   = CntLast;
                    state_d = LOAD;
`ifdef GRID_LINK_VERIFY_EN
                    wr_word_d = wr_data;
`endif
                end else if (rd_req) begin
                    cnt_d   = CntLast;
                    state_d = READ;
                end
            end
            LOAD: begin
                tx_shift = 1'b1;
                if (cnt_q == '0) begin
`ifdef GRID_LINK_VERIFY_EN
                    cnt_d   = CntLast;
                    chk_d   = 1'b1;
                    state_d = READ;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            DRAIN: begin
                rd_data_d  = rx_capture;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
`ifdef GRID_LINK_VERIFY_EN
                // Only readbacks that follow a write are compared.
                if (chk_q && (rx_capture != wr_word_q)) begin
                    verr_d = 1'b1;
                end
                chk_d = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            out_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            out_prev_q <= out_prev_d;
        end
    end

`ifdef GRID_LINK_VERIFY_EN
    // Latched write word, pending-compare flag and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_word_q <= '0;
            chk_q     <= 1'b0;
            verr_q    <= 1'b0;
        end else begin
            wr_word_q <= wr_word_d;
            chk_q     <= chk_d;
            verr_q    <= verr_d;
        end
    end

    assign verify_err = verr_q;
`else
    assign verify_err = 1'b0;
`endif

    // State decodes; memory controls fall to 0 as soon as reset forces IDLE.
    always_comb begin
        wr_ready        = (state_q == IDLE);
        busy            = (state_q != IDLE);
        mem_load_mode   = (state_q == LOAD);
        mem_output_mode = (state_q == READ);
        mem_serial_in   = (state_q == LOAD) ? tx_serial : 1'b0;
        rd_valid        = rd_valid_q;
        rd_data         = rd_data_q;
    end

endmodule
